tlp_stream_packer: RTL and testbench

TLP_STREAM_PACKER -- requirements
Module: tlp_stream_packer

---
 rtl/tlp_stream_packer_pkg.sv | 18 +
 rtl/sync_fifo_rewind.sv | 51 +++++
 rtl/tlp_stream_packer.sv | 197 +++++++++++++++++++
 tb/tb_tlp_stream_packer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_stream_packer_pkg.sv
// Shared types and constants for the TLP stream packer and its FIFO.
package tlp_stream_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } txState_t;

  localparam int HDR_PAD_W = 24;
  localparam int HDR_W     = 40;
  localparam int TX_W      = HDR_PAD_W + HDR_W;

  localparam int WORDS_PER_TLP_DEF = 15;
  localparam int DATA_DEPTH_DEF    = 64;
  localparam int HDR_DEPTH_DEF     = 4;

endpackage

// File: rtl/sync_fifo_rewind.sv
// Synchronous FIFO whose write pointer can be marked at a packet start and
// later rewound to that mark, discarding a partially written packet.
module sync_fifo_rewind #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64
) (
  input  logic                     InputClock,
  input  logic                     rst,
  input  logic                     writeEnable,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     markStart,
  input  logic                     rewind,
  input  logic                     readEnable,
  output logic [DATA_W-1:0]        readData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wrPtr;
  logic [AW:0]       rdPtr;
  logic [AW:0]       markPtr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      markPtr <= '0;
    end else begin
      if (rewind)
        wrPtr <= markPtr;
      else if (writeEnable)
        wrPtr <= wrPtr + 1'b1;
      if (markStart)
        markPtr <= wrPtr;
      if (readEnable)
        rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge InputClock) begin
    if (writeEnable && !rewind)
      mem[wrPtr[AW-1:0]] <= writeData;
  end

  assign readData = mem[rdPtr[AW-1:0]];
  assign count    = wrPtr - rdPtr;

endmodule

// File: rtl/tlp_stream_packer.sv
// Buffers whole packets (data words plus trailing header) and replays them
// downstream as header beat followed by data beats, dropping what cannot fit.
module tlp_stream_packer
  import tlp_stream_packer_pkg::*;
#(
  parameter int WORDS_PER_TLP = WORDS_PER_TLP_DEF,
  parameter int DATA_DEPTH    = DATA_DEPTH_DEF,
  parameter int HDR_DEPTH     = HDR_DEPTH_DEF
) (
  input  logic              InputClock,
  input  logic              rst,
  input  logic [TX_W-1:0]   TLPData,
  input  logic              DataWriteEnable,
  input  logic [HDR_W-1:0]  TLPHeader,
  input  logic              HeaderWriteEnable,
  input  logic              Enable,
  input  logic              ClearStats,
  output logic [TX_W-1:0]   TxData,
  output logic              TxValid,
  output logic              TxSop,
  output logic              TxEop,
  input  logic              TxReady,
  output logic [15:0]       DroppedPackets,
  output logic [7:0]        SyncErrors
);

  localparam int DAW  = $clog2(DATA_DEPTH);
  localparam int HAW  = $clog2(HDR_DEPTH);
  localparam int IDXW = $clog2(WORDS_PER_TLP + 1);

  localparam logic [IDXW-1:0] LAST_IDX      = IDXW'(WORDS_PER_TLP - 1);
  localparam logic [DAW:0]    WORDS_W       = (DAW + 1)'(WORDS_PER_TLP);
  localparam logic [DAW:0]    DATA_DEPTH_W  = (DAW + 1)'(DATA_DEPTH);
  localparam logic [HAW:0]    HDR_DEPTH_W   = (HAW + 1)'(HDR_DEPTH);

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [IDXW-1:0]  wordIdx;
  logic             accept;
  logic [DAW:0]     dataCount;
  logic [HAW:0]     hdrCount;
  logic [TX_W-1:0]  dataHead;
  logic [HDR_W-1:0] hdrHead;
  logic             dataPop;
  logic             hdrPop;

  logic [DAW:0] dataFree;
  logic         hdrRoom;
  logic         atLast;
  logic         pktStart;
  logic         startAccept;
  logic         curAccept;
  logic         goodEnd;
  logic         syncErr;
  logic         dataWrite;
  logic         dataRewind;
  logic         hdrWrite;
  logic         dropPkt;

  // Admission check: space freed by this cycle's pop counts as available.
  assign dataFree    = DATA_DEPTH_W - dataCount + {{DAW{1'b0}}, dataPop};
  assign hdrRoom     = (hdrCount != HDR_DEPTH_W) || hdrPop;
  assign atLast      = (wordIdx == LAST_IDX);
  assign pktStart    = DataWriteEnable && (wordIdx == '0);
  assign startAccept = Enable && (dataFree >= WORDS_W) && hdrRoom;
  assign curAccept   = pktStart ? startAccept : accept;

  // A header is only legal together with the final data word; a header
  // without data, or a final word without header, breaks the packet.
  assign goodEnd     = DataWriteEnable && HeaderWriteEnable && atLast;
  assign syncErr     = (HeaderWriteEnable && !goodEnd) ||
                       (DataWriteEnable && atLast && !HeaderWriteEnable);
  assign dataWrite   = DataWriteEnable && curAccept && !syncErr;
  assign dataRewind  = syncErr && (wordIdx != '0);
  assign hdrWrite    = goodEnd && curAccept;
  assign dropPkt     = goodEnd && !curAccept;

  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) begin
      wordIdx <= '0;
      accept  <= 1'b0;
    end else begin
      if (syncErr)
        wordIdx <= '0;
      else if (DataWriteEnable)
        wordIdx <= atLast ? '0 : wordIdx + 1'b1;
      if (pktStart)
        accept <= startAccept;
    end
  end

  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) begin
      DroppedPackets <= '0;
      SyncErrors     <= '0;
    end else if (ClearStats) begin
      DroppedPackets <= '0;
      SyncErrors     <= '0;
    end else begin
      if (dropPkt)
        DroppedPackets <= satInc16(DroppedPackets);
      if (syncErr)
        SyncErrors <= satInc8(SyncErrors);
    end
  end

  sync_fifo_rewind #(
    .DATA_W (TX_W),
    .DEPTH  (DATA_DEPTH)
  ) dataFifo (
    .InputClock  (InputClock),
    .rst         (rst),
    .writeEnable (dataWrite),
    .writeData   (TLPData),
    .markStart   (pktStart),
    .rewind      (dataRewind),
    .readEnable  (dataPop),
    .readData    (dataHead),
    .count       (dataCount)
  );

  sync_fifo_rewind #(
    .DATA_W (HDR_W),
    .DEPTH  (HDR_DEPTH)
  ) hdrFifo (
    .InputClock  (InputClock),
    .rst         (rst),
    .writeEnable (hdrWrite),
    .writeData   (TLPHeader),
    .markStart   (1'b0),
    .rewind      (1'b0),
    .readEnable  (hdrPop),
    .readData    (hdrHead),
    .count       (hdrCount)
  );

  txState_t        state;
  txState_t        nextState;
  logic [IDXW-1:0] beatCnt;

  always_ff @(posedge InputClock or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beatCnt <= '0;
    end else begin
      state <= nextState;
      if (hdrPop)
        beatCnt <= '0;
      else if (dataPop)
        beatCnt <= beatCnt + 1'b1;
    end
  end

  // Outputs depend only on state and FIFO heads, so they hold while stalled.
  always_comb begin
    nextState = state;
    TxValid   = 1'b0;
    TxSop     = 1'b0;
    TxEop     = 1'b0;
    TxData    = '0;
    hdrPop    = 1'b0;
    dataPop   = 1'b0;
    case (state)
      IDLE: begin
        if (hdrCount != '0)
          nextState = HDR;
      end
      HDR: begin
        TxValid = 1'b1;
        TxSop   = 1'b1;
        TxData  = {{HDR_PAD_W{1'b0}}, hdrHead};
        if (TxReady) begin
          hdrPop    = 1'b1;
          nextState = DATA;
        end
      end
      DATA: begin
        TxValid = 1'b1;
        TxData  = dataHead;
        TxEop   = (beatCnt == LAST_IDX);
        if (TxReady) begin
          dataPop = 1'b1;
          if (beatCnt == LAST_IDX)
            nextState = (hdrCount != '0) ? HDR : IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tlp_stream_packer.sv
// Randomised and directed bench for tlp_stream_packer with a packet-level
// reference model that predicts every downstream beat and both counters.
module tb_tlp_stream_packer;

  localparam int W      = 15;
  localparam int DDEPTH = 64;
  localparam int HDEPTH = 4;

  logic        InputClock = 1'b0;
  logic        rst;
  logic [63:0] TLPData;
  logic        DataWriteEnable;
  logic [39:0] TLPHeader;
  logic        HeaderWriteEnable;
  logic        Enable;
  logic        ClearStats;
  logic [63:0] TxData;
  logic        TxValid;
  logic        TxSop;
  logic        TxEop;
  logic        TxReady;
  logic [15:0] DroppedPackets;
  logic [7:0]  SyncErrors;

  tlp_stream_packer #(
    .WORDS_PER_TLP (W),
    .DATA_DEPTH    (DDEPTH),
    .HDR_DEPTH     (HDEPTH)
  ) dut (
    .InputClock        (InputClock),
    .rst               (rst),
    .TLPData           (TLPData),
    .DataWriteEnable   (DataWriteEnable),
    .TLPHeader         (TLPHeader),
    .HeaderWriteEnable (HeaderWriteEnable),
    .Enable            (Enable),
    .ClearStats        (ClearStats),
    .TxData            (TxData),
    .TxValid           (TxValid),
    .TxSop             (TxSop),
    .TxEop             (TxEop),
    .TxReady           (TxReady),
    .DroppedPackets    (DroppedPackets),
    .SyncErrors        (SyncErrors)
  );

  always #5 InputClock = ~InputClock;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = hold low, 1 = always ready, 2 = random 50%
  int readyMode = 1;
  always @(posedge InputClock) begin
    #1;
    case (readyMode)
      0:       TxReady = 1'b0;
      1:       TxReady = 1'b1;
      default: TxReady = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t       expQ[$];
  logic [63:0] curPkt[$];
  bit          pktAcc;
  int          dataOcc, hdrOcc;
  int          mDrop, mSync;
  bit          stalled;
  logic [63:0] hData;
  logic        hSop, hEop;
  int          cyc, xferCount, sopCount, dataBeats;
  int          firstXferCyc, lastXferCyc;
  logic [63:0] beatLog[64];
  int          beatLogN;

  always @(negedge InputClock) begin
    bit dpop, hpop, isLast, broken, acc;
    beat_t b;
    cyc++;
    if (rst) begin
      chk("rstTxValid", {63'd0, TxValid}, 64'd0);
      chk("rstDropped", {48'd0, DroppedPackets}, 64'd0);
      chk("rstSync", {56'd0, SyncErrors}, 64'd0);
      expQ.delete();
      curPkt.delete();
      pktAcc  = 0;
      dataOcc = 0;
      hdrOcc  = 0;
      mDrop   = 0;
      mSync   = 0;
      stalled = 0;
    end else begin
      if (stalled) begin
        chk("holdValid", {63'd0, TxValid}, 64'd1);
        chk("holdData", TxData, hData);
        chk("holdSopEop", {62'd0, TxSop, TxEop}, {62'd0, hSop, hEop});
      end
      chk("droppedCount", {48'd0, DroppedPackets}, 64'(mDrop));
      chk("syncCount", {56'd0, SyncErrors}, 64'(mSync));

      dpop = 0;
      hpop = 0;
      if (TxValid === 1'b1 && TxReady === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpectedBeat: got %h sop=%b eop=%b expected no beat", TxData, TxSop, TxEop);
        end else begin
          b = expQ.pop_front();
          chk("beatData", TxData, b.data);
          chk("beatSopEop", {62'd0, TxSop, TxEop}, {62'd0, b.sop, b.eop});
          if (b.sop) hpop = 1; else dpop = 1;
        end
        if (xferCount == 0) firstXferCyc = cyc;
        lastXferCyc = cyc;
        xferCount++;
        if (TxSop) begin
          sopCount++;
          dataBeats = 0;
        end else begin
          dataBeats++;
        end
        if (beatLogN < 64) beatLog[beatLogN] = TxData;
        beatLogN++;
      end
      stalled = (TxValid === 1'b1) && (TxReady !== 1'b1);
      hData = TxData;
      hSop  = TxSop;
      hEop  = TxEop;

      // Packet-level reference: position in packet is the number of words seen.
      if (DataWriteEnable || HeaderWriteEnable) begin
        isLast = (curPkt.size() == W - 1);
        broken = (HeaderWriteEnable && !(DataWriteEnable && isLast)) ||
                 (DataWriteEnable && isLast && !HeaderWriteEnable);
        if (broken) begin
          if (pktAcc) dataOcc -= curPkt.size();
          curPkt.delete();
          if (mSync < 255) mSync++;
        end else begin
          if (curPkt.size() == 0)
            pktAcc = Enable && (DDEPTH - dataOcc + int'(dpop) >= W) &&
                     (hdrOcc < HDEPTH || hpop);
          curPkt.push_back(TLPData);
          if (pktAcc) dataOcc++;
          if (HeaderWriteEnable) begin
            if (pktAcc) begin
              acc = 1;
              expQ.push_back('{data: {24'd0, TLPHeader}, sop: 1'b1, eop: 1'b0});
              for (int i = 0; i < W; i++)
                expQ.push_back('{data: curPkt[i], sop: 1'b0, eop: (i == W - 1)});
              hdrOcc++;
            end else begin
              acc = 0;
              if (mDrop < 65535) mDrop++;
            end
            curPkt.delete();
          end
        end
      end
      dataOcc -= int'(dpop);
      hdrOcc  -= int'(hpop);
      if (ClearStats) begin
        mDrop = 0;
        mSync = 0;
      end
    end
  end

  task automatic sendWords(input int n, input logic [63:0] base, input bit hdrAtEnd,
                           input logic [39:0] hdr, input int enOffAt);
    for (int i = 0; i < n; i++) begin
      if (i == enOffAt) Enable = 1'b0;
      DataWriteEnable   = 1'b1;
      TLPData           = base + 64'(i);
      HeaderWriteEnable = hdrAtEnd && (i == n - 1);
      TLPHeader         = hdr;
      @(posedge InputClock); #1;
    end
    DataWriteEnable   = 1'b0;
    HeaderWriteEnable = 1'b0;
  endtask

  task automatic clearStats();
    ClearStats = 1'b1;
    @(posedge InputClock); #1;
    ClearStats = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || TxValid === 1'b1) && n < 3000) begin
      @(negedge InputClock);
      n++;
    end
    chk(name, 64'(expQ.size()), 64'd0);
    @(posedge InputClock); #1;
  endtask

  initial begin
    int markSop, markX, n;
    logic [63:0] r;
    rst = 1'b1;
    TLPData = '0;
    TLPHeader = '0;
    DataWriteEnable = 1'b0;
    HeaderWriteEnable = 1'b0;
    Enable = 1'b1;
    ClearStats = 1'b0;
    repeat (3) @(posedge InputClock);
    #1;
    chk("resetTxData", TxData, 64'd0);
    chk("resetSopEop", {62'd0, TxSop, TxEop}, 64'd0);
    rst = 1'b0;
    @(posedge InputClock); #1;

    // Three back-to-back packets, words 1..45, always ready.
    readyMode = 1;
    xferCount = 0;
    beatLogN  = 0;
    for (int p = 0; p < 3; p++)
      sendWords(W, 64'(1 + p * W), 1'b1, 40'h00_C0DE_0000 | 40'(p), -1);
    drain("drainBasic");
    chk("basicBeats", 64'(xferCount), 64'd48);
    chk("basicNoGaps", 64'(lastXferCyc - firstXferCyc + 1), 64'd48);
    chk("basicHdr0", beatLog[0], 64'h0000_0000_C0DE_0000);
    chk("basicWord1", beatLog[1], 64'd1);
    chk("basicWord15", beatLog[15], 64'd15);
    chk("basicHdr1", beatLog[16], 64'h0000_0000_C0DE_0001);
    chk("basicWord45", beatLog[47], 64'd45);

    // Six packets while downstream is stalled: four fit, two are dropped.
    clearStats();
    readyMode = 0;
    for (int p = 0; p < 6; p++)
      sendWords(W, 64'(100 + p * W), 1'b1, 40'h11_0000_0000 | 40'(p), -1);
    repeat (3) @(posedge InputClock);
    #1;
    chk("stallDropped", {48'd0, DroppedPackets}, 64'd2);
    markSop = sopCount;
    readyMode = 1;
    drain("drainStall");
    chk("stallPktsOut", 64'(sopCount - markSop), 64'd4);

    // Header after ten words breaks sync; the following packet survives.
    clearStats();
    sendWords(10, 64'd900, 1'b0, '0, -1);
    HeaderWriteEnable = 1'b1;
    TLPHeader = 40'hBA_D0BA_D000;
    @(posedge InputClock); #1;
    HeaderWriteEnable = 1'b0;
    markSop = sopCount;
    beatLogN = 0;
    sendWords(W, 64'd200, 1'b1, 40'h22_0000_0001, -1);
    drain("drainSync");
    chk("syncErrors", {56'd0, SyncErrors}, 64'd1);
    chk("syncPktsOut", 64'(sopCount - markSop), 64'd1);
    chk("syncHdr", beatLog[0], 64'h0000_0022_0000_0001);
    chk("syncFirstWord", beatLog[1], 64'd200);
    chk("syncLastWord", beatLog[15], 64'd214);

    // Random backpressure over twenty spaced packets.
    clearStats();
    readyMode = 2;
    markSop = sopCount;
    for (int p = 0; p < 20; p++) begin
      r = {$urandom(), $urandom()};
      sendWords(W, r, 1'b1, r[63:24], -1);
      repeat ($urandom_range(24, 32)) @(posedge InputClock);
      #1;
    end
    readyMode = 1;
    drain("drainRandom");
    chk("randomNoDrop", {48'd0, DroppedPackets}, 64'd0);
    chk("randomPktsOut", 64'(sopCount - markSop), 64'd20);

    // Enable falls mid-packet: that packet completes, the next is dropped.
    clearStats();
    markSop = sopCount;
    sendWords(W, 64'd700, 1'b1, 40'h33_0000_0000, 7);
    sendWords(W, 64'd800, 1'b1, 40'h33_0000_0001, -1);
    Enable = 1'b1;
    drain("drainEnable");
    chk("enableDropped", {48'd0, DroppedPackets}, 64'd1);
    chk("enablePktsOut", 64'(sopCount - markSop), 64'd1);

    // Reset during the fifth data beat, with a partial packet also pending.
    markSop = sopCount;
    sendWords(W, 64'd300, 1'b1, 40'h44_0000_0000, -1);
    sendWords(4, 64'd400, 1'b0, '0, -1);
    n = 0;
    while (!(sopCount > markSop && dataBeats >= 5) && n < 300) begin
      @(negedge InputClock);
      n++;
    end
    chk("reachedBeat5", 64'(n < 300), 64'd1);
    @(posedge InputClock); #2;
    rst = 1'b1;
    #1;
    chk("rstTxValidNow", {63'd0, TxValid}, 64'd0);
    chk("rstTxDataNow", TxData, 64'd0);
    chk("rstDroppedNow", {48'd0, DroppedPackets}, 64'd0);
    chk("rstSyncNow", {56'd0, SyncErrors}, 64'd0);
    repeat (2) @(posedge InputClock);
    #1;
    rst = 1'b0;
    @(posedge InputClock); #1;
    markSop = sopCount;
    markX = xferCount;
    sendWords(W, 64'd500, 1'b1, 40'h55_0000_0000, -1);
    drain("drainAfterReset");
    chk("postRstPkts", 64'(sopCount - markSop), 64'd1);
    chk("postRstBeats", 64'(xferCount - markX), 64'd16);
    chk("postRstSync", {56'd0, SyncErrors}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
